// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// Latency: 34 cycles start-to-idle (32 RUN + FINISH); divide-by-zero bypasses RUN.
// Backpressure: EX_C_StallMD holds the pipeline while busy and EX needs the unit or HI/LO.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             EX_C_Start,
   input  logic [1:0]       EX_C_Op,
   input  logic [WIDTH-1:0] EX_A,
   input  logic [WIDTH-1:0] EX_B,
   input  logic             EX_C_ReadHiLo,
   input  logic             EX_C_WriteHi,
   input  logic             EX_C_WriteLo,
   input  logic [WIDTH-1:0] EX_WriteData,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             EX_C_StallMD
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;

   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_rem;
   logic               div_ge;

   assign signed_op = ~EX_C_Op[0];
   assign a_neg     = signed_op & EX_A[WIDTH-1];
   assign b_neg     = signed_op & EX_B[WIDTH-1];
   assign mag_a     = a_neg ? -EX_A : EX_A;
   assign mag_b     = b_neg ? -EX_B : EX_B;

   // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_rem   = div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;

   assign Busy         = (state_q != IDLE);
   assign EX_C_StallMD = Busy & (EX_C_Start | EX_C_ReadHiLo | EX_C_WriteHi | EX_C_WriteLo);
   assign HI           = hi_q;
   assign LO           = lo_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      unique case (state_q)
         IDLE: begin
            if (EX_C_Start) begin
               is_div_d = EX_C_Op[1];
               cnt_d    = '0;
               neg_d    = a_neg ^ b_neg;
               rneg_d   = a_neg;
               if (EX_C_Op[1] && (EX_B == '0)) begin
                  // Divide by zero: preload the architected result, no sign fix-up
                  acc_d   = {EX_A, {WIDTH{1'b1}}};
                  opnd_d  = '0;
                  neg_d   = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = FINISH;
               end else if (EX_C_Op[1]) begin
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
                  opnd_d  = mag_b;
                  state_d = RUN;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, mag_b};
                  opnd_d  = mag_a;
                  state_d = RUN;
               end
            end else begin
               if (EX_C_WriteHi) hi_d = EX_WriteData;
               if (EX_C_WriteLo) lo_d = EX_WriteData;
            end
         end
         RUN: begin
            if (is_div_q) begin
               acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = FINISH;
         end
         FINISH: begin
            if (is_div_q) begin
               lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic model of HI/LO.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] a = '0, b = '0, wd = '0;
   logic        rd = 1'b0, whi = 1'b0, wlo = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, stall;

   int errs = 0;
   int checks = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .EX_C_Start(start), .EX_C_Op(op), .EX_A(a), .EX_B(b),
      .EX_C_ReadHiLo(rd), .EX_C_WriteHi(whi), .EX_C_WriteLo(wlo),
      .EX_WriteData(wd), .HI(hi), .LO(lo), .Busy(busy), .EX_C_StallMD(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {HI, LO} as the architecture defines them.
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      case (o)
         2'd0: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
         end
         2'd1: begin
            p = {32'b0, x} * {32'b0, y};
            return p;
         end
         default: begin
            if (y == 32'd0) return {x, 32'hFFFFFFFF};
            if (o == 2'd2) begin
               sx = longint'($signed(x));
               sy = longint'($signed(y));
            end else begin
               sx = longint'({32'b0, x});
               sy = longint'({32'b0, y});
            end
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Entered 1 time unit after a rising edge with the unit idle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit hold_rd, input bit spam);
      logic [63:0] e;
      bit dz;
      e  = ref_op(o, x, y);
      dz = o[1] && (y == 32'd0);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; whi = 1'b0; wlo = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("hilo_hold_start", {hi, lo}, {m_hi, m_lo});
      if (hold_rd) rd = 1'b1;
      if (dz) begin
         @(posedge clk); #1;
         @(posedge clk); #1;
      end else begin
         for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (spam && i == 5) begin
               start = 1'b1; whi = 1'b1; wd = $urandom;
            end
            if (spam && i == 8) begin
               chk("stall_spam", 64'(stall), 64'd1);
               start = 1'b0; whi = 1'b0;
            end
            if (hold_rd && (i == 1 || i == 32)) chk("stall_rd", 64'(stall), 64'd1);
         end
         chk("busy_k32", 64'(busy), 64'd1);
         chk("hilo_k32", {hi, lo}, {m_hi, m_lo});
         @(posedge clk); #1;
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
      chk("result", {hi, lo}, e);
      chk("busy_done", 64'(busy), 64'd0);
      chk("stall_idle", 64'(stall), 64'd0);
      rd = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         4: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);
      rd = 1'b0;
      rst_n = 1'b1;

      // first edge after release takes the start
      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      run_op(2'd0, 32'hFFFFFFFD, 32'h00000005, 1'b0, 1'b0);
      chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
      chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
      run_op(2'd3, 32'h00000064, 32'h0, 1'b0, 1'b0);
      chk("divu_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
      run_op(2'd2, 32'hFFFFFF00, 32'h0, 1'b1, 1'b0);
      chk("div_zero", {hi, lo}, 64'hFFFFFF00_FFFFFFFF);
      run_op(2'd1, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b1);

      wlo = 1'b1; wd = 32'h12345678;
      @(posedge clk); #1;
      wlo = 1'b0;
      m_lo = 32'h12345678;
      chk("mtlo", 64'(lo), 64'h12345678);
      chk("mtlo_hi_kept", 64'(hi), 64'(m_hi));
      whi = 1'b1; wlo = 1'b1; wd = 32'hA5A5C3C3;
      @(posedge clk); #1;
      whi = 1'b0; wlo = 1'b0;
      m_hi = 32'hA5A5C3C3; m_lo = 32'hA5A5C3C3;
      chk("mt_both", {hi, lo}, {m_hi, m_lo});

      // start outranks a same-cycle MT write
      whi = 1'b1; wlo = 1'b1; wd = 32'hDEADBEEF;
      run_op(2'd0, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         logic [1:0]  ro;
         logic [31:0] rx, ry;
         ro = 2'($urandom_range(0, 3));
         rx = pick();
         ry = ($urandom_range(0, 5) == 0) ? 32'h0 : pick();
         run_op(ro, rx, ry, bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      // reset in the middle of RUN
      start = 1'b1; op = 2'd1; a = 32'hFFFF1234; b = 32'h89ABCDEF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rd = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("arst_hilo", {hi, lo}, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_stall", 64'(stall), 64'd0);
      m_hi = '0; m_lo = '0;
      #1;
      rst_n = 1'b1;
      rd = 1'b0;
      run_op(2'd1, 32'd2, 32'd3, 1'b0, 1'b0);
      chk("post_reset_mul", {hi, lo}, 64'd6);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
